// File: rtl/axi_wr_ctrl.sv
// AXI write-burst master: turns one command into a single INCR burst on AW/W,
// collects the B response (or gives up after TIMEOUT cycles) and reports completion.
module axi_wr_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]              cmd_len,
    input  logic [2:0]              cmd_size,
    input  logic [7:0]              cmd_id,

    input  logic                    dat_valid,
    output logic                    dat_ready,
    input  logic [DATA_WIDTH-1:0]   dat_data,
    input  logic [DATA_WIDTH/8-1:0] dat_strb,

    output logic                    done,
    output logic [1:0]              done_resp,
    output logic [1:0]              done_err,

    output logic [7:0]              AWID,
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic [7:0]              AWLEN,
    output logic [2:0]              AWSIZE,
    output logic [1:0]              AWBURST,
    output logic                    AWLOCK,
    output logic [3:0]              AWCACHE,
    output logic [2:0]              AWPROT,
    output logic                    AWVALID,
    input  logic                    AWREADY,

    output logic [3:0]              WID,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    WLAST,
    output logic                    WVALID,
    input  logic                    WREADY,

    input  logic [7:0]              BID,
    input  logic [1:0]              BRESP,
    input  logic                    BVALID,
    output logic                    BREADY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam int            TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    state_t                  r_state;
    state_t                  w_state_next;

    logic                    r_out_en;
    logic [7:0]              r_awid;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [7:0]              r_awlen;
    logic [2:0]              r_awsize;
    logic [1:0]              r_awburst;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_wstrb;
    logic                    r_wvalid;
    logic                    r_wlast;
    logic [8:0]              r_beats_loaded;
    logic [TW-1:0]           r_timer;
    logic                    r_done;
    logic [1:0]              r_done_resp;
    logic [1:0]              r_done_err;

    logic                    w_cmd_ready;
    logic                    w_awvalid;
    logic                    w_dat_ready;
    logic                    w_bready;
    logic                    w_cmd_hs;
    logic                    w_dat_hs;
    logic                    w_w_hs;
    logic                    w_b_hs;
    logic                    w_timeout;
    logic                    w_resp_end;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // cmd_ready stays low during the done pulse so a new command lands one cycle later.
    always_comb begin
        w_state_next = r_state;
        w_cmd_ready  = 1'b0;
        w_awvalid    = 1'b0;
        w_dat_ready  = 1'b0;
        w_bready     = 1'b0;
        case (r_state)
            IDLE: begin
                w_cmd_ready = r_out_en && !r_done;
                if (cmd_valid && w_cmd_ready) begin
                    w_state_next = ADDR;
                end
            end
            ADDR: begin
                w_awvalid = 1'b1;
                if (AWREADY) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                w_dat_ready = (r_beats_loaded <= {1'b0, r_awlen}) && (!r_wvalid || WREADY);
                if (r_wvalid && WREADY && r_wlast) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                w_bready = 1'b1;
                if (BVALID || (r_timer == TIMER_LAST)) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_cmd_hs   = cmd_valid && w_cmd_ready;
    assign w_dat_hs   = dat_valid && w_dat_ready;
    assign w_w_hs     = r_wvalid && WREADY;
    assign w_b_hs     = BVALID && w_bready;
    assign w_timeout  = w_bready && !BVALID && (r_timer == TIMER_LAST);
    assign w_resp_end = w_b_hs || w_timeout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_en       <= 1'b0;
            r_awid         <= '0;
            r_awaddr       <= '0;
            r_awlen        <= '0;
            r_awsize       <= '0;
            r_awburst      <= '0;
            r_wdata        <= '0;
            r_wstrb        <= '0;
            r_wvalid       <= 1'b0;
            r_wlast        <= 1'b0;
            r_beats_loaded <= '0;
            r_timer        <= '0;
            r_done         <= 1'b0;
            r_done_resp    <= '0;
            r_done_err     <= '0;
        end else begin
            r_out_en <= 1'b1;

            if (w_cmd_hs) begin
                r_awid    <= cmd_id;
                r_awaddr  <= cmd_addr;
                r_awlen   <= cmd_len;
                r_awsize  <= cmd_size;
                r_awburst <= 2'b01;
            end

            // Nine-bit count so a 256-beat burst reaches len+1 without wrapping.
            if (w_cmd_hs) begin
                r_beats_loaded <= '0;
            end else if (w_dat_hs) begin
                r_beats_loaded <= r_beats_loaded + 9'd1;
            end

            if (w_dat_hs) begin
                r_wdata  <= dat_data;
                r_wstrb  <= dat_strb;
                r_wvalid <= 1'b1;
                r_wlast  <= (r_beats_loaded == {1'b0, r_awlen});
            end else if (w_w_hs) begin
                r_wvalid <= 1'b0;
                r_wlast  <= 1'b0;
            end

            if (w_bready && !w_resp_end) begin
                r_timer <= r_timer + TW'(1);
            end else begin
                r_timer <= '0;
            end

            r_done      <= w_resp_end;
            r_done_resp <= w_b_hs ? BRESP : (w_timeout ? 2'b10 : 2'b00);
            r_done_err  <= {w_timeout, w_b_hs && (BID != r_awid)};
        end
    end

    assign cmd_ready = w_cmd_ready;
    assign dat_ready = w_dat_ready;
    assign BREADY    = w_bready;
    assign AWVALID   = w_awvalid;

    assign AWID      = r_awid;
    assign AWADDR    = r_awaddr;
    assign AWLEN     = r_awlen;
    assign AWSIZE    = r_awsize;
    assign AWBURST   = r_awburst;
    assign AWLOCK    = 1'b0;
    assign AWCACHE   = 4'd0;
    assign AWPROT    = 3'd0;

    assign WID       = r_awid[3:0];
    assign WDATA     = r_wdata;
    assign WSTRB     = r_wstrb;
    assign WLAST     = r_wlast;
    assign WVALID    = r_wvalid;

    assign done      = r_done;
    assign done_resp = r_done_resp;
    assign done_err  = r_done_err;

endmodule

// File: tb/tb_axi_wr_ctrl.sv
// Directed bench for axi_wr_ctrl: a background AXI slave / data source drives the
// DUT and logs traffic; each scenario task checks the logs against hand-derived values.
module tb_axi_wr_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [2:0]  cmd_size = '0;
    logic [7:0]  cmd_id = '0;
    logic        dat_valid = 1'b0;
    logic        dat_ready;
    logic [31:0] dat_data = '0;
    logic [3:0]  dat_strb = '0;
    logic        done;
    logic [1:0]  done_resp;
    logic [1:0]  done_err;
    logic [7:0]  AWID;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWLOCK;
    logic [3:0]  AWCACHE;
    logic [2:0]  AWPROT;
    logic        AWVALID;
    logic        AWREADY = 1'b0;
    logic [3:0]  WID;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY = 1'b0;
    logic [7:0]  BID = '0;
    logic [1:0]  BRESP = '0;
    logic        BVALID = 1'b0;
    logic        BREADY;

    int checks = 0;
    int errors = 0;

    axi_wr_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_id(cmd_id),
        .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_data(dat_data), .dat_strb(dat_strb),
        .done(done), .done_resp(done_resp), .done_err(done_err),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    always #5 clk = ~clk;

    // Environment configuration
    int          cyc = 0;
    int          aw_delay = 0;
    int          wr_mode = 0;
    bit          gap_on = 1'b0;
    int          b_mode = 0;
    logic [7:0]  b_id = '0;
    logic [1:0]  b_resp = '0;
    int          src_idx = 0;
    int          src_n = 0;
    bit          wr_tog = 1'b0;

    // Traffic logs
    int          aw_vcyc, aw_hold, aw_first_cyc, aw_cnt, aw_stab_err;
    logic [52:0] aw_prev;
    logic [31:0] aw_addr_l;
    logic [7:0]  aw_len_l, aw_id_l, aw_fixed_l;
    logic [2:0]  aw_size_l;
    logic [1:0]  aw_burst_l;
    bit          aw_done, last_seen, in_resp, w_prev_stall;
    logic [36:0] w_prev;
    int          wv_early, w_stab_err, w_cnt, bready_early, resp_cyc;
    int          done_cnt, done_cyc, cr_in_done, br_in_done, cmd_cyc;
    logic [31:0] w_data [0:299];
    logic [3:0]  w_strb [0:299];
    logic        w_last [0:299];
    logic [3:0]  w_id   [0:299];
    logic [1:0]  done_resp_l, done_err_l;

    function automatic logic [31:0] data_of(input int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    function automatic logic [3:0] strb_of(input int i);
        return (i % 2 == 0) ? 4'hF : 4'h3;
    endfunction

    // Slave / source drive on the falling edge, then log what will handshake next rise.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            AWREADY = AWVALID && (aw_vcyc >= aw_delay);
            if (wr_mode == 0) begin
                WREADY = 1'b1;
            end else begin
                wr_tog = !wr_tog;
                WREADY = wr_tog;
            end
            dat_valid = (src_idx < src_n) && !(gap_on && (cyc % 3 == 1));
            dat_data  = data_of(src_idx);
            dat_strb  = strb_of(src_idx);
            case (b_mode)
                1:       BVALID = BREADY;
                2:       BVALID = 1'b1;
                default: BVALID = 1'b0;
            endcase
            BID   = b_id;
            BRESP = b_resp;
            #1;
            if (AWVALID) begin
                if (aw_vcyc > 0 && {AWADDR, AWLEN, AWSIZE, AWID, AWBURST} != aw_prev) aw_stab_err++;
                aw_prev = {AWADDR, AWLEN, AWSIZE, AWID, AWBURST};
                if (aw_vcyc == 0) aw_first_cyc = cyc;
                aw_vcyc++;
                if (AWREADY) begin
                    aw_cnt++;
                    aw_hold    = aw_vcyc;
                    aw_vcyc    = 0;
                    aw_addr_l  = AWADDR;
                    aw_len_l   = AWLEN;
                    aw_size_l  = AWSIZE;
                    aw_id_l    = AWID;
                    aw_burst_l = AWBURST;
                    aw_fixed_l = {AWLOCK, AWCACHE, AWPROT};
                    aw_done    = 1'b1;
                end
            end
            if (WVALID && !aw_done) wv_early++;
            if (w_prev_stall && (!WVALID || {WDATA, WSTRB, WLAST} != w_prev)) w_stab_err++;
            w_prev_stall = WVALID && !WREADY;
            w_prev = {WDATA, WSTRB, WLAST};
            if (WVALID && WREADY) begin
                if (w_cnt < 300) begin
                    w_data[w_cnt] = WDATA;
                    w_strb[w_cnt] = WSTRB;
                    w_last[w_cnt] = WLAST;
                    w_id[w_cnt]   = WID;
                end
                w_cnt++;
                if (WLAST) begin
                    aw_done   = 1'b0;
                    last_seen = 1'b1;
                end
            end
            if (dat_valid && dat_ready) src_idx++;
            if (BREADY && !last_seen) bready_early++;
            if (BREADY && !in_resp) begin
                in_resp  = 1'b1;
                resp_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc    = cyc;
                done_resp_l = done_resp;
                done_err_l  = done_err;
                if (cmd_ready) cr_in_done++;
                if (BREADY) br_in_done++;
                in_resp   = 1'b0;
                last_seen = 1'b0;
                $display("txn %0d done: cyc=%0d resp=%0d err=%0d beats=%0d", done_cnt, cyc, done_resp, done_err, w_cnt);
            end
        end
    end

    task automatic clear_logs;
        aw_delay = 0; wr_mode = 0; gap_on = 1'b0; b_mode = 0; b_id = '0; b_resp = '0;
        src_idx = 0; src_n = 0; wr_tog = 1'b0;
        aw_vcyc = 0; aw_hold = 0; aw_first_cyc = 0; aw_cnt = 0; aw_stab_err = 0; aw_prev = '0;
        aw_done = 1'b0; last_seen = 1'b0; in_resp = 1'b0; w_prev_stall = 1'b0; w_prev = '0;
        wv_early = 0; w_stab_err = 0; w_cnt = 0; bready_early = 0; resp_cyc = 0;
        done_cnt = 0; done_cyc = 0; cr_in_done = 0; br_in_done = 0; cmd_cyc = 0;
    endtask

    task automatic do_cmd(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [7:0] id);
        bit got = 1'b0;
        @(negedge clk); #2;
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_size = s; cmd_id = id;
        for (int i = 0; i < 100; i++) begin
            if (cmd_ready) begin
                got = 1'b1;
                cmd_cyc = cyc;
                break;
            end
            @(negedge clk); #2;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if (!got) begin errors++; $display("FAIL cmd_accept: cmd_ready got %0b required 1", cmd_ready); end
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #2;
            if (done_cnt >= target) break;
        end
        checks++;
        if (done_cnt < target) begin errors++; $display("FAIL done_wait: done count %0d required %0d", done_cnt, target); end
    endtask

    task automatic test_reset;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if ({cmd_ready, dat_ready, AWVALID, WVALID, WLAST, BREADY, done} !== 7'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b required 0000000", {cmd_ready, dat_ready, AWVALID, WVALID, WLAST, BREADY, done});
        end
        checks++;
        if ({AWADDR, AWID, AWLEN, AWSIZE, AWBURST, WDATA, WSTRB, WID, done_resp, done_err} !== '0) begin
            errors++; $display("FAIL reset_payload: AWADDR %0h WDATA %0h AWBURST %0d required all 0", AWADDR, WDATA, AWBURST);
        end
        @(negedge clk); #3;
        reset = 1'b1;
        @(negedge clk); #2;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_cmd_ready: got %0b required 1", cmd_ready); end
        checks++;
        if ({AWVALID, dat_ready, BREADY} !== 3'b0) begin errors++; $display("FAIL reset_release_idle: got %b required 000", {AWVALID, dat_ready, BREADY}); end
    endtask

    task automatic test_basic;
        clear_logs();
        b_mode = 2; b_id = 8'h05; b_resp = 2'b00; src_n = 4;
        do_cmd(32'h0000_1000, 8'd3, 3'd2, 8'h05);
        wait_done(1, 100);
        b_mode = 0;
        checks++;
        if (aw_first_cyc != cmd_cyc + 1) begin errors++; $display("FAIL basic_aw_latency: AWVALID at cyc %0d required %0d", aw_first_cyc, cmd_cyc + 1); end
        checks++;
        if ({aw_addr_l, aw_len_l, aw_size_l, aw_id_l, aw_burst_l} !== {32'h1000, 8'd3, 3'd2, 8'h05, 2'b01}) begin
            errors++; $display("FAIL basic_aw_fields: addr %0h len %0d size %0d id %0h burst %0d required 1000 3 2 5 1", aw_addr_l, aw_len_l, aw_size_l, aw_id_l, aw_burst_l);
        end
        checks++;
        if (aw_fixed_l !== 8'd0 || aw_hold != 1) begin errors++; $display("FAIL basic_aw_fixed: lock/cache/prot %0h hold %0d required 0 1", aw_fixed_l, aw_hold); end
        checks++;
        if (w_cnt != 4) begin errors++; $display("FAIL basic_beats: got %0d required 4", w_cnt); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (w_data[i] !== data_of(i) || w_strb[i] !== strb_of(i) || w_last[i] !== (i == 3) || w_id[i] !== 4'h5) begin
                errors++; $display("FAIL basic_beat%0d: data %0h strb %0h last %0b wid %0h required %0h %0h %0b 5", i, w_data[i], w_strb[i], w_last[i], w_id[i], data_of(i), strb_of(i), (i == 3));
            end
        end
        checks++;
        if (done_resp_l !== 2'b00 || done_err_l !== 2'b00) begin errors++; $display("FAIL basic_done: resp %0d err %0d required 0 0", done_resp_l, done_err_l); end
        checks++;
        if (bready_early != 0 || wv_early != 0 || cr_in_done != 0) begin
            errors++; $display("FAIL basic_order: bready_early %0d wvalid_early %0d cmd_ready_at_done %0d required 0 0 0", bready_early, wv_early, cr_in_done);
        end
    endtask

    task automatic test_aw_delay;
        clear_logs();
        aw_delay = 5; b_mode = 1; b_id = 8'h21; src_n = 1;
        do_cmd(32'h0000_2000, 8'd0, 3'd2, 8'h21);
        wait_done(1, 100);
        checks++;
        if (aw_hold != 6 || aw_stab_err != 0) begin errors++; $display("FAIL awdelay_hold: cycles %0d unstable %0d required 6 0", aw_hold, aw_stab_err); end
        checks++;
        if (wv_early != 0) begin errors++; $display("FAIL awdelay_early_w: got %0d required 0", wv_early); end
        checks++;
        if (w_cnt != 1 || w_last[0] !== 1'b1 || w_data[0] !== data_of(0)) begin
            errors++; $display("FAIL awdelay_single: beats %0d last %0b data %0h required 1 1 %0h", w_cnt, w_last[0], w_data[0], data_of(0));
        end
    endtask

    task automatic test_stall;
        clear_logs();
        wr_mode = 1; gap_on = 1'b1; b_mode = 1; b_id = 8'h05; src_n = 8;
        do_cmd(32'h0000_3000, 8'd7, 3'd2, 8'h05);
        wait_done(1, 300);
        checks++;
        if (w_cnt != 8) begin errors++; $display("FAIL stall_beats: got %0d required 8", w_cnt); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (w_data[i] !== data_of(i) || w_last[i] !== (i == 7)) begin
                errors++; $display("FAIL stall_beat%0d: data %0h last %0b required %0h %0b", i, w_data[i], w_last[i], data_of(i), (i == 7));
            end
        end
        checks++;
        if (w_stab_err != 0) begin errors++; $display("FAIL stall_hold: unstable samples %0d required 0", w_stab_err); end
    endtask

    task automatic test_bid_mismatch;
        clear_logs();
        b_mode = 1; b_id = 8'h06; b_resp = 2'b10; src_n = 2;
        do_cmd(32'h0000_4000, 8'd1, 3'd2, 8'h05);
        wait_done(1, 100);
        checks++;
        if (done_resp_l !== 2'b10 || done_err_l !== 2'b01) begin errors++; $display("FAIL bid_mismatch: resp %0d err %0d required 2 1", done_resp_l, done_err_l); end
    endtask

    task automatic test_timeout;
        clear_logs();
        b_mode = 0; src_n = 1;
        do_cmd(32'h0000_5000, 8'd0, 3'd2, 8'h03);
        wait_done(1, 200);
        checks++;
        if (done_cyc - resp_cyc != 16) begin errors++; $display("FAIL timeout_latency: got %0d required 16", done_cyc - resp_cyc); end
        checks++;
        if (done_resp_l !== 2'b10 || done_err_l !== 2'b10) begin errors++; $display("FAIL timeout_status: resp %0d err %0d required 2 2", done_resp_l, done_err_l); end
        checks++;
        if (br_in_done != 0 || cr_in_done != 0) begin errors++; $display("FAIL timeout_done_cycle: bready %0d cmd_ready %0d required 0 0", br_in_done, cr_in_done); end
        @(negedge clk); #2;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL timeout_cmd_ready: got %0b required 1", cmd_ready); end
    endtask

    task automatic test_back_to_back;
        int c2 = -1;
        clear_logs();
        b_mode = 1; b_id = 8'h07; src_n = 4;
        do_cmd(32'h0000_6000, 8'd1, 3'd2, 8'h07);
        cmd_valid = 1'b1; cmd_addr = 32'h0000_7000; cmd_len = 8'd1; cmd_id = 8'h07;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #2;
            if (cmd_ready) begin
                c2 = cyc;
                break;
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if (c2 != done_cyc + 1 || done_cnt != 1) begin errors++; $display("FAIL b2b_next_cmd: accepted cyc %0d required %0d", c2, done_cyc + 1); end
        wait_done(2, 100);
        checks++;
        if (w_cnt != 4 || w_data[3] !== data_of(3) || aw_addr_l !== 32'h7000 || cr_in_done != 0) begin
            errors++; $display("FAIL b2b_second: beats %0d data %0h addr %0h required 4 %0h 7000", w_cnt, w_data[3], aw_addr_l, data_of(3));
        end
    endtask

    task automatic test_long_burst;
        int bad = 0;
        clear_logs();
        b_mode = 1; b_id = 8'h09; src_n = 256;
        do_cmd(32'h0001_0000, 8'd255, 3'd2, 8'h09);
        wait_done(1, 1000);
        for (int i = 0; i < 256; i++) begin
            if (w_data[i] !== data_of(i) || w_last[i] !== (i == 255)) bad++;
        end
        checks++;
        if (w_cnt != 256 || bad != 0 || aw_len_l !== 8'd255) begin
            errors++; $display("FAIL long_burst: beats %0d bad %0d awlen %0d required 256 0 255", w_cnt, bad, aw_len_l);
        end
    endtask

    task automatic test_reset_mid_burst;
        clear_logs();
        b_mode = 1; b_id = 8'h0A; src_n = 8;
        do_cmd(32'h0000_8000, 8'd7, 3'd2, 8'h0A);
        for (int i = 0; i < 100; i++) begin
            if (w_cnt >= 2) break;
            @(negedge clk); #2;
        end
        checks++;
        if (w_cnt < 2) begin errors++; $display("FAIL midrst_reach_beat2: beats %0d required 2", w_cnt); end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, dat_ready, AWVALID, WVALID, WLAST, BREADY, done} !== 7'b0) begin
            errors++; $display("FAIL midrst_ctrl: got %b required 0000000", {cmd_ready, dat_ready, AWVALID, WVALID, WLAST, BREADY, done});
        end
        checks++;
        if ({AWADDR, AWID, AWLEN, AWSIZE, AWBURST, WDATA, WSTRB, WID, done_resp, done_err} !== '0) begin
            errors++; $display("FAIL midrst_payload: AWADDR %0h WDATA %0h WID %0h required all 0", AWADDR, WDATA, WID);
        end
        repeat (2) @(negedge clk);
        #2;
        clear_logs();
        b_mode = 1; b_id = 8'h0B; src_n = 2;
        reset = 1'b1;
        do_cmd(32'h0000_9000, 8'd1, 3'd2, 8'h0B);
        wait_done(1, 100);
        checks++;
        if (w_cnt != 2 || w_data[0] !== data_of(0) || w_last[1] !== 1'b1 || done_resp_l !== 2'b00 || done_err_l !== 2'b00) begin
            errors++; $display("FAIL midrst_recover: beats %0d data %0h last %0b resp %0d err %0d required 2 %0h 1 0 0", w_cnt, w_data[0], w_last[1], done_resp_l, done_err_l, data_of(0));
        end
    endtask

    initial begin
        clear_logs();
        test_reset();
        test_basic();
        test_aw_delay();
        test_stall();
        test_bid_mismatch();
        test_timeout();
        test_back_to_back();
        test_long_burst();
        test_reset_mid_burst();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_wr_ctrl.md
AXI_WR_CTRL -- requirements
Module: axi_wr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of the command address and AWADDR.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of data/WDATA; strobe width is DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT, default 1024, the maximum number of cycles spent in RESP without a B handshake.
REQ-004 SHALL have one clock and one reset: clk (in, 1, rising-edge clock) and reset (in, 1, asynchronous active-low reset).
REQ-005 SHALL have these command ports: cmd_valid (in, 1); cmd_ready (out, 1); cmd_addr (in, ADDR_WIDTH); cmd_len (in, 8, beats-1); cmd_size (in, 3); cmd_id (in, 8).
REQ-006 SHALL have these data-source ports: dat_valid (in, 1); dat_ready (out, 1); dat_data (in, DATA_WIDTH); dat_strb (in, DATA_WIDTH/8).
REQ-007 SHALL have these completion ports: done (out, 1, one-cycle pulse); done_resp (out, 2); done_err (out, 2; bit0 = ID mismatch, bit1 = timeout).
REQ-008 SHALL drive AWID[8], AWADDR, AWLEN[8], AWSIZE[3], AWBURST[2], AWLOCK, AWCACHE[4], AWPROT[3] and AWVALID, and SHALL receive AWREADY.
REQ-009 SHALL drive WID[4], WDATA, WSTRB, WLAST and WVALID, and SHALL receive WREADY.
REQ-010 SHALL receive BID[8], BRESP[2] and BVALID, and SHALL drive BREADY.

Function
REQ-011 SHALL implement an FSM with states IDLE, ADDR, DATA and RESP; reset state is IDLE.
REQ-012 SHALL assert cmd_ready only in IDLE; when cmd_valid and cmd_ready are both high on edge N, it SHALL latch all command fields, enter ADDR and assert AWVALID from cycle N+1.
REQ-013 SHALL hold AWVALID and all AW fields stable until AWREADY is sampled high; an AW handshake SHALL move the FSM to DATA.
REQ-014 SHALL drive the fixed fields AWBURST=2'b01 (INCR), AWLOCK=0, AWCACHE=0, AWPROT=0, AWID=cmd_id and WID=cmd_id[3:0].
REQ-015 SHALL assert no WVALID before the AW handshake has completed.
REQ-016 SHALL register the W channel: dat_ready = (state==DATA) && (beats_loaded <= len) && (!WVALID || WREADY).
REQ-017 SHALL load dat_data/dat_strb into WDATA/WSTRB and set WVALID on every dat_valid && dat_ready handshake.
REQ-018 SHALL hold a WVALID that is high, together with its WDATA/WSTRB/WLAST, until WREADY; WVALID SHALL never depend combinationally on WREADY.
REQ-019 SHALL count beat counters 0..len in 9 bits so that len=255 (256 beats) does not wrap.
REQ-020 SHALL assert WLAST exactly on beat index len; len=0 SHALL give a single beat with WLAST=1.
REQ-021 SHALL, on the W handshake carrying WLAST, clear WVALID and WLAST in the next cycle and enter RESP.
REQ-022 SHALL assert BREADY only in RESP; a B handshake SHALL pulse done for one cycle with done_resp=BRESP and done_err[0]=(BID!=AWID), then return to IDLE.
REQ-023 SHALL count cycles in RESP; reaching TIMEOUT without a B handshake SHALL pulse done with done_resp=2'b10 and done_err[1]=1, deassert BREADY and return to IDLE.
REQ-024 SHALL keep cmd_ready low in the cycle done pulses, so the earliest next command handshake is the cycle after done.
REQ-025 SHALL stall without data loss when dat_valid is low mid-burst (WVALID drops after a completed beat) and when WREADY is held low.
REQ-026 SHALL ignore a BVALID that arrives in any state other than RESP; BREADY stays low.

Reset
REQ-027 SHALL, while reset=0 (asynchronously, including mid-burst), force state to IDLE, clear all counters and hold AWVALID, WVALID, WLAST, BREADY, dat_ready, done and cmd_ready at 0, all AW/W payload outputs at 0 and done_resp/done_err at 0.
REQ-028 SHALL assert cmd_ready on the first rising clk edge after reset deasserts.

Verification
REQ-029 SHALL cover: cmd addr=0x1000, len=3, size=2, id=0x05, AWREADY=1 and WREADY=1, four data beats, BRESP=0 -> AW issued 1 cycle after cmd, 4 W beats with WLAST on the 4th, done with resp=0 and err=0.
REQ-030 SHALL cover: len=0 with AWREADY delayed 5 cycles -> AWVALID and fields stable for 6 cycles, no WVALID before the AW handshake, a single beat with WLAST=1.
REQ-031 SHALL cover: len=7 with WREADY toggling 1-0 and dat_valid gaps -> exactly 8 beats in order, WDATA stable whenever WVALID=1 and WREADY=0.
REQ-032 SHALL cover: BID=0x06 against AWID=0x05 with BRESP=2'b10 -> done with resp=2'b10 and err=2'b01.
REQ-033 SHALL cover: TIMEOUT=16 with BVALID never asserted -> done 16 cycles after entering RESP with resp=2'b10 and err=2'b10, then cmd_ready=1.
REQ-034 SHALL cover: reset asserted at beat 2 of len=7 -> all outputs 0 immediately, and a new command after release completes normally.
